// File: rtl/matrix_defs.sv
// Shared matrix geometry and sequencer state encodings, reused by the
// datapath and the HPS bridge.
package matrix_defs;

  localparam int N_MAX  = 5;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : matrix_defs

// File: rtl/rise_detect.sv
// One-cycle pulse on each rising edge of a level that is already
// registered in the clk_in domain.
module rise_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic slow_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      slow_q <= 1'b0;
    end else begin
      slow_q <= d;
    end
  end

  assign pulse = d & ~slow_q;

endmodule : rise_detect

// File: rtl/matrix_step_sequencer.sv
// Walks a size x size matrix row-major, issuing one element index per
// divided-clock step over a valid/ready handshake.
module matrix_step_sequencer #(
  parameter int N      = matrix_defs::N_MAX,
  parameter int IDX_W  = matrix_defs::IDX_W,
  parameter int ADDR_W = matrix_defs::ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              slow_clk,
  input  logic              start,
  input  logic [IDX_W-1:0]  size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [IDX_W-1:0]  row,
  output logic [IDX_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  import matrix_defs::*;

  if ((1 << IDX_W) <= N) begin : g_bad_idx_w
    $error("IDX_W too narrow for N");
  end
  if ((1 << ADDR_W) < N * N) begin : g_bad_addr_w
    $error("ADDR_W too narrow for N*N");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  size_q,  size_d;
  logic [IDX_W-1:0]  row_q,   row_d;
  logic [IDX_W-1:0]  col_q,   col_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              last_q,  last_d;
  logic              valid_q, valid_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  logic              tick;
  logic              size_bad;
  logic [IDX_W-1:0]  smax;

  rise_detect u_rise_detect (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (slow_clk),
    .pulse  (tick)
  );

  // row*N as a sum of shifted copies of row, one per set bit of N
  function automatic logic [ADDR_W-1:0] row_base(input logic [IDX_W-1:0] r);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (((N >> b) & 1) != 0) begin
        acc = acc + (ADDR_W'(r) << b);
      end
    end
    return acc;
  endfunction

  assign size_bad = (size == '0) || (size > IDX_W'(N));
  assign smax     = size_q - IDX_W'(1);

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    last_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          size_d = size;
          busy_d = 1'b1;
          err_d  = size_bad;
          if (size_bad) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            row_d   = '0;
            col_d   = '0;
            addr_d  = '0;
          end
        end
      end

      // last is only ever raised together with valid
      ST_WAIT: begin
        if (tick) begin
          state_d = ST_ISSUE;
          valid_d = 1'b1;
          last_d  = (row_q == smax) && (col_q == smax);
        end
      end

      ST_ISSUE: begin
        valid_d = 1'b1;
        last_d  = last_q;
        if (elem_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            if (col_q == smax) begin
              col_d = '0;
              row_d = row_q + IDX_W'(1);
            end else begin
              col_d = col_q + IDX_W'(1);
            end
            addr_d = row_base(row_d) + ADDR_W'(col_d);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign elem_valid = valid_q;
  assign row        = row_q;
  assign col        = col_q;
  assign addr       = addr_q;
  assign last       = last_q;

endmodule : matrix_step_sequencer
